// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR pseudo-random generator.
// The defaults describe a maximal-length 16-bit generator.
package lfsr_pkg;

    typedef enum logic [0:0] {
        LFSR_GALOIS    = 1'b0,
        LFSR_FIBONACCI = 1'b1
    } lfsr_mode_e;

    localparam int          LFSR_WIDTH_MIN     = 8;
    localparam int          LFSR_WIDTH_MAX     = 32;
    localparam int          LFSR_DEFAULT_WIDTH = 16;
    localparam logic [15:0] LFSR_DEFAULT_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED  = 16'hACE1;

    function automatic logic lfsr_width_ok(input int width);
        return (width >= LFSR_WIDTH_MIN) && (width <= LFSR_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/lfsr_prng_if.sv
// Control and ready/valid output bundle between the PRNG (master) and its consumer (slave).
interface lfsr_prng_if
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_DEFAULT_WIDTH
);

    logic             en;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] rand_num;
    logic             rand_valid;
    logic             rand_ready;
    logic             wrap;
    logic             zero_fix;

    modport master (
        input  en, seed_load, seed_in, rand_ready,
        output rand_num, rand_valid, wrap, zero_fix
    );

    modport slave (
        output en, seed_load, seed_in, rand_ready,
        input  rand_num, rand_valid, wrap, zero_fix
    );

endinterface

// File: rtl/lfsr_step.sv
// Combinational LFSR next-state function, Galois (right shift, conditional tap XOR)
// or Fibonacci (left shift, parity of tapped bits into bit 0).
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter lfsr_mode_e       MODE  = LFSR_GALOIS
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    genvar gi;

    generate
        if (MODE == LFSR_GALOIS) begin : g_galois
            // The bit shifted out of stage 0 is XORed into every tapped stage.
            for (gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi == WIDTH - 1) begin : g_top
                    assign next_state[gi] = TAPS[gi] & state[0];
                end else begin : g_mid
                    assign next_state[gi] = state[gi+1] ^ (TAPS[gi] & state[0]);
                end
            end
        end else begin : g_fibonacci
            assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random number source with a ready/valid output, runtime reseeding,
// a zero-seed substitution pulse and a wrap pulse when the sequence returns to its seed.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED),
    parameter lfsr_mode_e       MODE  = LFSR_GALOIS
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_prng_if.master bus
);

    generate
        if (!lfsr_width_ok(WIDTH)) begin : g_bad_width
            $error("lfsr_prng: WIDTH must lie in 8..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_prng: SEED must be non-zero");
        end
        if (TAPS == '0) begin : g_bad_taps
            $error("lfsr_prng: TAPS must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] rand_num_reg;
    logic             rand_valid_reg;
    logic             wrap_reg;
    logic             zero_fix_reg;
    logic [WIDTH-1:0] count_reg;

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] load_value;
    logic             step_en;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_step (
        .state      (state_reg),
        .next_state (next_state)
    );

    assign step_en    = bus.en & ~bus.seed_load & (~rand_valid_reg | bus.rand_ready);
    assign load_value = (bus.seed_in == '0) ? SEED : bus.seed_in;
    // Tap masks that are not primitive could map some state onto zero; fall back to
    // SEED so the register can never enter the all-zero lockup.
    assign step_value = (next_state == '0) ? SEED : next_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= SEED;
            seed_reg       <= SEED;
            rand_num_reg   <= '0;
            rand_valid_reg <= 1'b0;
            wrap_reg       <= 1'b0;
            zero_fix_reg   <= 1'b0;
            count_reg      <= '0;
        end else begin
            wrap_reg     <= 1'b0;
            zero_fix_reg <= 1'b0;
            if (bus.seed_load) begin
                // Any word on offer is dropped, even if the consumer accepts it now.
                state_reg      <= load_value;
                seed_reg       <= load_value;
                rand_valid_reg <= 1'b0;
                count_reg      <= '0;
                zero_fix_reg   <= (bus.seed_in == '0);
            end else if (step_en) begin
                state_reg      <= step_value;
                rand_num_reg   <= step_value;
                rand_valid_reg <= 1'b1;
                if (step_value == seed_reg) begin
                    wrap_reg  <= 1'b1;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (bus.rand_ready) begin
                rand_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.rand_num   = rand_num_reg;
    assign bus.rand_valid = rand_valid_reg;
    assign bus.wrap       = wrap_reg;
    assign bus.zero_fix   = zero_fix_reg;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: a reference LFSR model pushes expected words on each
// step it predicts, and they are popped and compared once the DUT has clocked.
module tb_lfsr_prng;
    import lfsr_pkg::*;

    localparam logic [15:0] TAPS_C = 16'hB400;
    localparam logic [15:0] SEED_C = 16'hACE1;

    logic clk;
    logic rst;

    lfsr_prng_if #(.WIDTH(16)) g_if ();
    lfsr_prng_if #(.WIDTH(16)) f_if ();

    lfsr_prng #(
        .WIDTH (16),
        .TAPS  (TAPS_C),
        .SEED  (SEED_C),
        .MODE  (LFSR_GALOIS)
    ) u_gal (
        .clk (clk),
        .rst (rst),
        .bus (g_if.master)
    );

    lfsr_prng #(
        .WIDTH (16),
        .TAPS  (TAPS_C),
        .SEED  (SEED_C),
        .MODE  (LFSR_FIBONACCI)
    ) u_fib (
        .clk (clk),
        .rst (rst),
        .bus (f_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    logic [15:0] m_state;
    logic [15:0] m_seed;
    logic        m_valid;
    logic [15:0] sb[$];
    bit          seen[0:65535];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] gal_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? TAPS_C : 16'h0000);
    endfunction

    task automatic drive(input logic e, input logic r, input logic l, input logic [15:0] s);
        g_if.en = e;  g_if.rand_ready = r;  g_if.seed_load = l;  g_if.seed_in = s;
        f_if.en = e;  f_if.rand_ready = r;  f_if.seed_load = l;  f_if.seed_in = s;
    endtask

    // One clock: update the model from the driven inputs, clock, then compare.
    task automatic tick(input string tag, input bit verbose);
        logic        step;
        logic        exp_zf;
        logic        exp_wrap;
        logic [15:0] exp_word;
        step     = 1'b0;
        exp_zf   = 1'b0;
        exp_wrap = 1'b0;
        if (rst) begin
            m_state = SEED_C;
            m_seed  = SEED_C;
            m_valid = 1'b0;
            sb.delete();
        end else if (g_if.seed_load) begin
            m_state = (g_if.seed_in == 16'h0) ? SEED_C : g_if.seed_in;
            m_seed  = m_state;
            m_valid = 1'b0;
            exp_zf  = (g_if.seed_in == 16'h0);
        end else if (g_if.en && (!m_valid || g_if.rand_ready)) begin
            m_state  = gal_next(m_state);
            m_valid  = 1'b1;
            exp_wrap = (m_state == m_seed);
            step     = 1'b1;
            sb.push_back(m_state);
        end else if (g_if.rand_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val({tag, ".valid"}, 32'(g_if.rand_valid), 32'(m_valid));
        check_val({tag, ".zero_fix"}, 32'(g_if.zero_fix), 32'(exp_zf));
        check_val({tag, ".wrap"}, 32'(g_if.wrap), 32'(exp_wrap));
        if (rst) check_val({tag, ".rst_num"}, 32'(g_if.rand_num), 32'h0);
        if (step) begin
            exp_word = sb.pop_front();
            check_val({tag, ".num"}, 32'(g_if.rand_num), 32'(exp_word));
        end
        if (verbose)
            $display("%s: en=%0b rdy=%0b load=%0b seed=%h -> num=%h valid=%0b wrap=%0b zero_fix=%0b",
                     tag, g_if.en, g_if.rand_ready, g_if.seed_load, g_if.seed_in,
                     g_if.rand_num, g_if.rand_valid, g_if.wrap, g_if.zero_fix);
    endtask

    initial begin
        int          wraps;
        int          zeros;
        int          repeats;
        logic [15:0] word;
        logic [15:0] wrap_word;
        n_checks  = 0;
        n_pass    = 0;
        wraps     = 0;
        zeros     = 0;
        repeats   = 0;
        wrap_word = 16'h0;
        rst       = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        tick("reset0", 1'b1);
        tick("reset1", 1'b1);

        // Free run through the whole period.
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 65535; i++) begin
            tick("run", (i < 3));
            word = g_if.rand_num;
            if (i == 0) begin
                check_val("gal_first", 32'(word), 32'hE270);
                check_val("fib_first", 32'(f_if.rand_num), 32'h59C3);
                check_val("fib_valid", 32'(f_if.rand_valid), 32'h1);
            end
            if (i == 1) check_val("gal_second", 32'(word), 32'h7138);
            if (wraps == 0) begin
                if (seen[word]) repeats++;
                if (word == 16'h0) zeros++;
            end
            seen[word] = 1'b1;
            if (g_if.wrap) begin
                wraps++;
                wrap_word = word;
            end
        end
        $display("freerun: 65535 steps, wraps=%0d wrap_word=%h repeats=%0d zeros=%0d",
                 wraps, wrap_word, repeats, zeros);
        check_val("wrap_count", 32'(wraps), 32'd1);
        check_val("wrap_word", 32'(wrap_word), 32'hACE1);
        check_val("repeats", 32'(repeats), 32'd0);
        check_val("zeros", 32'(zeros), 32'd0);

        // Back-pressure: word and state held for three cycles.
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick("stall", 1'b1);
            check_val("stall_hold", 32'(g_if.rand_num), 32'hACE1);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) tick("resume", 1'b1);

        // Consumer takes the word while disabled: valid drops, no advance.
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        tick("drain", 1'b1);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tick("after_drain", 1'b1);

        // Zero seed is replaced by SEED, with the load beating an accepted word.
        drive(1'b1, 1'b1, 1'b1, 16'h0);
        tick("load_zero", 1'b1);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tick("post_zero", 1'b1);
        check_val("post_zero_word", 32'(g_if.rand_num), 32'hE270);

        drive(1'b1, 1'b1, 1'b1, 16'h1234);
        tick("load_1234", 1'b1);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) tick("seeded", 1'b1);

        // Reset mid-handshake, also while a load is requested.
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tick("stall2", 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 16'h5555);
        tick("rst_mid", 1'b1);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tick("post_rst", 1'b1);
        check_val("post_rst_word", 32'(g_if.rand_num), 32'hE270);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_prng.md
LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 SHALL have parameter WIDTH, 16, LFSR state/output width, legal range 8..32.
REQ-002 SHALL have parameter TAPS, 16'hB400, feedback mask of WIDTH bits, bit k set = tap at stage k+1.
REQ-003 SHALL have parameter SEED, 16'hACE1, non-zero reset/fallback seed of WIDTH bits.
REQ-004 SHALL have parameter MODE, LFSR_GALOIS, LFSR_GALOIS or LFSR_FIBONACCI.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  permits the LFSR to advance.
REQ-008 SHALL have port seed_load  input  1  load seed_in into the LFSR this cycle.
REQ-009 SHALL have port seed_in  input  WIDTH  seed value.
REQ-010 SHALL have port rand_num  output  WIDTH  current output word.
REQ-011 SHALL have port rand_valid  output  1  rand_num holds an unconsumed word.
REQ-012 SHALL have port rand_ready  input  1  consumer accepts rand_num when rand_valid=1.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when the sequence returns to the active seed.
REQ-014 SHALL have port zero_fix  output  1  one-cycle pulse when a zero seed is replaced by SEED.

Function
REQ-015 SHALL compute step = en & ~seed_load & (~rand_valid | rand_ready).
REQ-016 SHALL, in Galois mode, compute next = (state >> 1) ^ (state[0] ? TAPS : 0).
REQ-017 SHALL, in Fibonacci mode, compute next = {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-018 SHALL, on step, load state and rand_num with next and set rand_valid=1 on the same edge (1-cycle latency).
REQ-019 SHALL, when rand_valid=1 and rand_ready=0, hold rand_num and state unchanged regardless of en.
REQ-020 SHALL, when rand_valid=1, rand_ready=1 and en=0, clear rand_valid next cycle without advancing state.
REQ-021 SHALL, on seed_load, load state and seed_reg with seed_in (or SEED if seed_in==0), clear rand_valid, clear the step counter; seed_load has priority over step.
REQ-022 SHALL pulse zero_fix for exactly the cycle after a seed_load with seed_in==0.
REQ-023 SHALL keep a WIDTH-bit step counter, incremented on each step, cleared on seed_load and on wrap.
REQ-024 SHALL pulse wrap in the cycle after a step where next == seed_reg; the counter then reads 0.
REQ-025 SHALL never hold state==0; no input sequence may reach the all-zero lockup state.
REQ-026 SHALL treat simultaneous seed_load and rand_ready as a load; the presented word is discarded.

Reset
REQ-027 SHALL on rst=1 set state=SEED, seed_reg=SEED, rand_num=0, rand_valid=0, wrap=0, zero_fix=0, counter=0.
REQ-028 SHALL give rst priority over seed_load and step, including mid-handshake.

Structure
REQ-029 SHALL place the mode enum (LFSR_GALOIS, LFSR_FIBONACCI) and default TAPS/SEED constants in shared package lfsr_pkg.
REQ-030 SHALL implement the next-state function as combinational sub-module lfsr_step (parameters WIDTH, TAPS, MODE).
REQ-031 SHALL reject illegal WIDTH or SEED==0 by elaboration-time assertion.

Verification
REQ-032 Galois, defaults, reset then en=1, rand_ready=1 -> rand_num 16'hE270 then 16'h7138, rand_valid=1 from first step.
REQ-033 Fibonacci, defaults, one step -> rand_num 16'h59C3.
REQ-034 Galois, free-run 65535 steps -> wrap pulses once on the step yielding rand_num 16'hACE1; no repeats, no zero word before that.
REQ-035 rand_ready=0 for 3 cycles with en=1 -> rand_num and state stable, then advance one word per cycle after ready=1.
REQ-036 seed_load with seed_in=0 -> zero_fix=1 one cycle, rand_valid=0, next step yields 16'hE270.
REQ-037 rst asserted while rand_valid=1, rand_ready=0 -> next cycle rand_valid=0, rand_num=0, state=16'hACE1.
